// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: debounces keypad codes, owns the calculator state
// register and issues registered one-cycle control pulses to the datapath.
module calc_key_sequencer #(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] cont,
  output logic       clr,
  output logic       err,
  output logic [1:0] state,
  output logic [3:0] digit_cnt
);

  typedef enum logic [1:0] {
    RDY1 = 2'b00,
    OP   = 2'b01,
    RDY2 = 2'b11,
    RES  = 2'b10
  } state_t;

  localparam logic [3:0] DMAX = 4'(DIGITS);
  localparam logic [7:0] DB   = 8'(DEBOUNCE);

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_ADD = 4'hC;
  localparam logic [3:0] K_EQ  = 4'hD;
  localparam logic [3:0] K_RCL = 4'hE;
  localparam logic [3:0] K_STO = 4'hF;

  localparam logic [7:0] C_SUB  = 8'h80;
  localparam logic [7:0] C_LDA  = 8'h40;
  localparam logic [7:0] C_LDB  = 8'h20;
  localparam logic [7:0] C_LOP  = 8'h10;
  localparam logic [7:0] C_GETA = 8'h08;
  localparam logic [7:0] C_GETB = 8'h04;
  localparam logic [7:0] C_SETM = 8'h02;
  localparam logic [7:0] C_EXEC = 8'h01;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] cont_q;
  logic       clr_q, err_q;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic [3:0] prev_code_q;
  logic       armed_q, armed_d;
  logic       accept;
  logic       is_digit;
  logic       room;

  assign is_digit = (key_code <= 4'd9);
  assign room     = (cnt_q < DMAX);

  // The count only grows while the same code stays held; it saturates so a
  // long hold never wraps back onto the acceptance value.
  always_comb begin
    db_cnt_d = '0;
    armed_d  = armed_q;
    accept   = 1'b0;
    if (!key_valid) begin
      db_cnt_d = '0;
      armed_d  = 1'b1;
    end else begin
      if (db_cnt_q != '0 && key_code == prev_code_q)
        db_cnt_d = (db_cnt_q >= DB) ? DB : db_cnt_q + 8'd1;
      else
        db_cnt_d = 8'd1;
      if (armed_q && db_cnt_d == DB) begin
        accept  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RDY1;
      cnt_q       <= '0;
      cont_q      <= '0;
      clr_q       <= 1'b0;
      err_q       <= 1'b0;
      db_cnt_q    <= '0;
      prev_code_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      armed_q     <= armed_d;
      prev_code_q <= key_code;
      cont_q      <= '0;
      clr_q       <= 1'b0;
      err_q       <= 1'b0;
      if (accept) begin
        if (key_code == K_CLR) begin
          clr_q   <= 1'b1;
          state_q <= RDY1;
          cnt_q   <= '0;
        end else begin
          unique case (state_q)
            RDY1: begin
              if (is_digit) begin
                if (room) begin
                  cont_q <= C_LDA;
                  cnt_q  <= cnt_q + 4'd1;
                end else begin
                  err_q  <= 1'b1;
                end
              end else begin
                case (key_code)
                  K_RCL: begin cont_q <= C_GETA; cnt_q <= DMAX; end
                  K_STO: cont_q <= C_SETM;
                  K_SUB: begin cont_q <= C_LOP | C_SUB; state_q <= OP; end
                  K_ADD: begin cont_q <= C_LOP; state_q <= OP; end
                  default: ;
                endcase
              end
            end
            OP: begin
              if (is_digit) begin
                cont_q  <= C_LDB;
                cnt_q   <= 4'd1;
                state_q <= RDY2;
              end else begin
                case (key_code)
                  K_RCL: begin cont_q <= C_GETB; cnt_q <= DMAX; state_q <= RDY2; end
                  K_SUB: cont_q <= C_LOP | C_SUB;
                  K_ADD: cont_q <= C_LOP;
                  K_STO: cont_q <= C_SETM;
                  default: ;
                endcase
              end
            end
            RDY2: begin
              if (is_digit) begin
                if (room) begin
                  cont_q <= C_LDB;
                  cnt_q  <= cnt_q + 4'd1;
                end else begin
                  err_q  <= 1'b1;
                end
              end else begin
                case (key_code)
                  K_RCL: begin cont_q <= C_GETB; cnt_q <= DMAX; end
                  K_EQ:  begin cont_q <= C_EXEC; cnt_q <= '0; state_q <= RES; end
                  default: ;
                endcase
              end
            end
            RES: begin
              // A new operand after a result starts a fresh calculation.
              if (is_digit) begin
                clr_q   <= 1'b1;
                cont_q  <= C_LDA;
                cnt_q   <= 4'd1;
                state_q <= RDY1;
              end else begin
                case (key_code)
                  K_RCL: begin
                    clr_q   <= 1'b1;
                    cont_q  <= C_GETA;
                    cnt_q   <= DMAX;
                    state_q <= RDY1;
                  end
                  K_SUB: begin cont_q <= C_LOP | C_SUB; state_q <= OP; end
                  K_ADD: begin cont_q <= C_LOP; state_q <= OP; end
                  K_STO: cont_q <= C_SETM;
                  default: ;
                endcase
              end
            end
            default: state_q <= RDY1;
          endcase
        end
      end
    end
  end

  assign cont      = cont_q;
  assign clr       = clr_q;
  assign err       = err_q;
  assign state     = state_q;
  assign digit_cnt = cnt_q;

endmodule
